// File: rtl/seg_tube_writer.sv
// Memory-mapped 8-digit seven-segment hex display: a CPU-writable data and control
// register, scanned four slots per refresh with digits k and k+4 lit together.
module seg_tube_writer #(
    parameter int unsigned SCAN_DIV  = 100000,
    parameter logic [31:0] ADDR_DATA = 32'hFFFF_FC60,
    parameter logic [31:0] ADDR_CTRL = 32'hFFFF_FC64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] rd_data,
    output logic [7:0]  tubSel,
    output logic [7:0]  tubLeft,
    output logic [7:0]  tubRight
);

    localparam int unsigned CNT_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned DIGITS   = 8;
    localparam logic [8:0]  CTRL_RST = 9'h0FF;

    logic [31:0]      data_q, data_d;
    logic [8:0]       ctrl_q, ctrl_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [1:0]       slot_q, slot_d;
    logic [7:0]       sel_q, sel_d;
    logic [7:0]       left_q, left_d;
    logic [7:0]       right_q, right_d;

    logic [2:0]       hi_idx;
    logic [7:0]       vis;
    logic [3:0]       nib_r, nib_l;

    function automatic logic [7:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 8'h3F;
            4'h1: seg7 = 8'h06;
            4'h2: seg7 = 8'h5B;
            4'h3: seg7 = 8'h4F;
            4'h4: seg7 = 8'h66;
            4'h5: seg7 = 8'h6D;
            4'h6: seg7 = 8'h7D;
            4'h7: seg7 = 8'h07;
            4'h8: seg7 = 8'h7F;
            4'h9: seg7 = 8'h6F;
            4'hA: seg7 = 8'h77;
            4'hB: seg7 = 8'h7C;
            4'hC: seg7 = 8'h39;
            4'hD: seg7 = 8'h5E;
            4'hE: seg7 = 8'h79;
            default: seg7 = 8'h71;
        endcase
    endfunction

    // Readback is combinational so a load in the same cycle as the address sees it.
    always_comb begin
        rd_data = '0;
        if (address == ADDR_DATA) begin
            rd_data = data_q;
        end else if (address == ADDR_CTRL) begin
            rd_data = {23'd0, ctrl_q};
        end
    end

    // Highest non-zero nibble; stays 0 for an all-zero value so digit 0 always survives.
    always_comb begin
        hi_idx = 3'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (data_q[4*i +: 4] != 4'h0) begin
                hi_idx = 3'(i);
            end
        end
    end

    always_comb begin
        vis = '0;
        for (int i = 0; i < DIGITS; i++) begin
            vis[i] = ctrl_q[i] && (!ctrl_q[8] || (3'(i) <= hi_idx));
        end
    end

    assign nib_r = data_q[{1'b0, slot_q, 2'b00} +: 4];
    assign nib_l = data_q[{1'b1, slot_q, 2'b00} +: 4];

    always_comb begin
        data_d  = data_q;
        ctrl_d  = ctrl_q;
        div_d   = div_q + CNT_W'(1);
        slot_d  = slot_q;
        sel_d   = '0;
        left_d  = '0;
        right_d = '0;

        if (wr_en && (address == ADDR_DATA)) begin
            data_d = write_data;
        end
        if (wr_en && (address == ADDR_CTRL)) begin
            ctrl_d = write_data[8:0];
        end

        if (div_q == CNT_W'(SCAN_DIV - 1)) begin
            div_d  = '0;
            slot_d = slot_q + 2'd1;
        end

        for (int i = 0; i < DIGITS; i++) begin
            sel_d[i] = vis[i] && (2'(i) == slot_q);
        end
        if (vis[{1'b0, slot_q}]) begin
            right_d = seg7(nib_r);
        end
        if (vis[{1'b1, slot_q}]) begin
            left_d = seg7(nib_l);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            ctrl_q  <= CTRL_RST;
            div_q   <= '0;
            slot_q  <= '0;
            sel_q   <= '0;
            left_q  <= '0;
            right_q <= '0;
        end else begin
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
            div_q   <= div_d;
            slot_q  <= slot_d;
            sel_q   <= sel_d;
            left_q  <= left_d;
            right_q <= right_d;
        end
    end

    assign tubSel   = sel_q;
    assign tubLeft  = left_q;
    assign tubRight = right_q;

endmodule
